// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the memory-access pipeline stage
// Contents: load/store type codes, MEM FSM state type, default bus timeout.
package mem_pkg;

   localparam logic [2:0] LT_LB   = 3'b000;
   localparam logic [2:0] LT_LH   = 3'b001;
   localparam logic [2:0] LT_LW   = 3'b010;
   localparam logic [2:0] LT_LBU  = 3'b100;
   localparam logic [2:0] LT_LHU  = 3'b101;
   localparam logic [2:0] LT_NONE = 3'b111;

   localparam logic [1:0] ST_SB   = 2'b00;
   localparam logic [1:0] ST_SH   = 2'b01;
   localparam logic [1:0] ST_SW   = 2'b10;
   localparam logic [1:0] ST_NONE = 2'b11;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

   typedef enum logic [0:0] {
      S_IDLE        = 1'b0,
      S_WAIT_RVALID = 1'b1
   } mem_state_t;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// rtl/mem_stage_lsu_align.sv - byte-lane formatting for stores and load extraction
// Ports:
//   off        in  2   byte offset within the word (addr[1:0])
//   load_type  in  3   load type code
//   store_type in  2   store type code
//   is_load    in  1   instruction is a load
//   is_store   in  1   instruction is a store
//   store_data in  32  register data to store
//   rdata      in  32  word returned by the bus
//   be         out 4   byte enables
//   wdata      out 32  lane-replicated store data
//   load_data  out 32  extracted and extended load result
//   misalign   out 1   access not naturally aligned
module lsu_align
   import mem_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  load_type,
   input  logic [1:0]  store_type,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic        misalign
);

   logic [31:0] lane;
   logic        half_access;
   logic        word_access;

   always_comb begin
      be    = 4'b1111;
      wdata = store_data;
      if (is_store) begin
         case (store_type)
            ST_SB: begin
               be    = 4'b0001 << off;
               wdata = {4{store_data[7:0]}};
            end
            ST_SH: begin
               be    = 4'b0011 << off;
               wdata = {2{store_data[15:0]}};
            end
            default: begin
               be    = 4'b1111;
               wdata = store_data;
            end
         endcase
      end
   end

   // Move the addressed lane down to bit 0 before extending.
   assign lane = rdata >> {off, 3'b000};

   always_comb begin
      case (load_type)
         LT_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
         LT_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
         LT_LBU:  load_data = {24'b0, lane[7:0]};
         LT_LHU:  load_data = {16'b0, lane[15:0]};
         default: load_data = lane;
      endcase
   end

   always_comb begin
      half_access = (is_load && (load_type == LT_LH || load_type == LT_LHU)) ||
                    (is_store && store_type == ST_SH);
      word_access = (is_load && load_type == LT_LW) ||
                    (is_store && store_type == ST_SW);
      misalign    = (half_access && off[0]) || (word_access && (off != 2'b00));
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: data-bus access FSM, stall, MEM/WB register
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alu_result_mem .. memtoreg_mem   EX/MEM register outputs
//   dmem_req/we/addr/be/wdata        bus request side (out)
//   dmem_gnt/rvalid/rdata            bus response side (in)
//   stall_mem                        upstream freeze
//   wb_data_wb, rd_wb, wb_reg_file_wb, misalign_err_wb, bus_err_wb   MEM/WB register
module mem_stage
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] rs2_data_mem,
   input  logic [4:0]  rd_mem,
   input  logic        mem_write_mem,
   input  logic [2:0]  mem_load_type_mem,
   input  logic [1:0]  mem_store_type_mem,
   input  logic        wb_reg_file_mem,
   input  logic        memtoreg_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        stall_mem,
   output logic [31:0] wb_data_wb,
   output logic [4:0]  rd_wb,
   output logic        wb_reg_file_wb,
   output logic        misalign_err_wb,
   output logic        bus_err_wb
);

   mem_state_t  state;
   mem_state_t  state_next;
   logic [15:0] wait_cnt;
   logic        is_store;
   logic        is_load;
   logic        misalign;
   logic        access;
   logic        timeout_hit;
   logic        complete;
   logic [31:0] load_data;

   // A store wins if both enables are set, so a single access is ever issued.
   assign is_store  = mem_write_mem && (mem_store_type_mem != ST_NONE);
   assign is_load   = !is_store && memtoreg_mem && (mem_load_type_mem != LT_NONE);
   assign access    = (is_store || is_load) && !misalign;
   assign dmem_we   = is_store;
   assign dmem_addr = {alu_result_mem[31:2], 2'b00};

   lsu_align u_align (
      .off        (alu_result_mem[1:0]),
      .load_type  (mem_load_type_mem),
      .store_type (mem_store_type_mem),
      .is_load    (is_load),
      .is_store   (is_store),
      .store_data (rs2_data_mem),
      .rdata      (dmem_rdata),
      .be         (dmem_be),
      .wdata      (dmem_wdata),
      .load_data  (load_data),
      .misalign   (misalign)
   );

   // Abort takes priority over a late gnt/rvalid in the same cycle, and the
   // request is withdrawn so the bus never sees a grant for an aborted access.
   assign timeout_hit = (TIMEOUT != 0) && access && (wait_cnt == 16'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (access && !timeout_hit && is_load && dmem_gnt) begin
               state_next = S_WAIT_RVALID;
            end
         end
         S_WAIT_RVALID: begin
            if (timeout_hit || dmem_rvalid) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      dmem_req = 1'b0;
      complete = 1'b0;
      case (state)
         S_IDLE: begin
            if (access && !timeout_hit) begin
               dmem_req = 1'b1;
               complete = is_store && dmem_gnt;
            end
         end
         S_WAIT_RVALID: begin
            complete = !timeout_hit && dmem_rvalid;
         end
         default: begin
            dmem_req = 1'b0;
            complete = 1'b0;
         end
      endcase
      stall_mem = access && !complete && !timeout_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (complete || timeout_hit || !access) begin
         wait_cnt <= '0;
      end else if (stall_mem && (TIMEOUT != 0)) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_data_wb      <= '0;
         rd_wb           <= '0;
         wb_reg_file_wb  <= 1'b0;
         misalign_err_wb <= 1'b0;
         bus_err_wb      <= 1'b0;
      end else if (stall_mem) begin
         wb_data_wb      <= '0;
         rd_wb           <= '0;
         wb_reg_file_wb  <= 1'b0;
         misalign_err_wb <= 1'b0;
         bus_err_wb      <= 1'b0;
      end else if (timeout_hit) begin
         wb_data_wb      <= '0;
         rd_wb           <= '0;
         wb_reg_file_wb  <= 1'b0;
         misalign_err_wb <= 1'b0;
         bus_err_wb      <= 1'b1;
      end else if (misalign) begin
         wb_data_wb      <= '0;
         rd_wb           <= rd_mem;
         wb_reg_file_wb  <= 1'b0;
         misalign_err_wb <= 1'b1;
         bus_err_wb      <= 1'b0;
      end else begin
         wb_data_wb      <= is_load ? load_data : alu_result_mem;
         rd_wb           <= rd_mem;
         wb_reg_file_wb  <= wb_reg_file_mem;
         misalign_err_wb <= 1'b0;
         bus_err_wb      <= 1'b0;
      end
   end

endmodule
